// File: rtl/fetch_queue_if.sv
// Fetch-to-decode bundle: two fetched instructions in, two oldest queued entries out.
interface fetch_queue_if #(
    parameter int DEPTH = 16,
    parameter int EXT_W = 8
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic [31:0]      i_PC1;
    logic [31:0]      i_IR1;
    logic [EXT_W-1:0] i_EXT1;
    logic [31:0]      i_PC2;
    logic [31:0]      i_IR2;
    logic [EXT_W-1:0] i_EXT2;
    logic [1:0]       i_is_valid;
    logic             stall_ICache;
    logic             flush_BR;
    logic [1:0]       i_deq;

    logic [31:0]      o_PC1;
    logic [31:0]      o_IR1;
    logic [EXT_W-1:0] o_EXT1;
    logic [31:0]      o_PC2;
    logic [31:0]      o_IR2;
    logic [EXT_W-1:0] o_EXT2;
    logic [1:0]       o_is_valid;
    logic             ID_status;
    logic             o_is_full;
    logic [CW-1:0]    o_count;
    logic             o_overflow;

    modport master (
        output i_PC1, i_IR1, i_EXT1, i_PC2, i_IR2, i_EXT2,
               i_is_valid, stall_ICache, flush_BR, i_deq,
        input  o_PC1, o_IR1, o_EXT1, o_PC2, o_IR2, o_EXT2,
               o_is_valid, ID_status, o_is_full, o_count, o_overflow
    );

    modport slave (
        input  i_PC1, i_IR1, i_EXT1, i_PC2, i_IR2, i_EXT2,
               i_is_valid, stall_ICache, flush_BR, i_deq,
        output o_PC1, o_IR1, o_EXT1, o_PC2, o_IR2, o_EXT2,
               o_is_valid, ID_status, o_is_full, o_count, o_overflow
    );
endinterface

// File: rtl/fetch_queue.sv
// Circular instruction queue between fetch and decode: up to two in, up to two out per cycle,
// show-ahead outputs, all-or-nothing pair enqueue, single-cycle branch flush.
module fetch_queue #(
    parameter int DEPTH       = 16,
    parameter int EXT_W       = 8,
    parameter int FULL_MARGIN = 4
) (
    input  logic          clk,
    input  logic          rst,
    fetch_queue_if.slave  bus
);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam int AW = CW - 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] FULL_TH = CW'(DEPTH - FULL_MARGIN);

    typedef struct packed {
        logic [31:0]      pc;
        logic [31:0]      ir;
        logic [EXT_W-1:0] ext;
    } entry_t;

    entry_t mem [DEPTH];

    logic [CW-1:0] head, tail;
    logic [CW-1:0] count, free, n_in, deq_req, n_out;
    logic [1:0]    valid_in, valid_out;
    logic          accept;
    logic          overflow_q;
    logic [AW-1:0] wr_idx0, wr_idx1, rd_idx0, rd_idx1;
    entry_t        e0, e1;

    always_comb begin
        count    = head - tail;
        free     = DEPTH_C - count;
        valid_in = bus.stall_ICache ? 2'b00 : bus.i_is_valid;
        case (valid_in)
            2'b11:   n_in = CW'(2);
            2'b10:   n_in = CW'(1);
            default: n_in = '0;
        endcase
        case (bus.i_deq)
            2'd0:    deq_req = '0;
            2'd1:    deq_req = CW'(1);
            default: deq_req = CW'(2);
        endcase
        n_out   = (deq_req > count) ? count : deq_req;
        // Space freed by this cycle's dequeue is deliberately not credited.
        accept  = (n_in <= free);
        wr_idx0 = head[AW-1:0];
        wr_idx1 = wr_idx0 + AW'(1);
        rd_idx0 = tail[AW-1:0];
        rd_idx1 = rd_idx0 + AW'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head       <= '0;
            tail       <= '0;
            overflow_q <= 1'b0;
        end else if (bus.flush_BR) begin
            head       <= '0;
            tail       <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (accept)
                head <= head + n_in;
            tail       <= tail + n_out;
            overflow_q <= !accept;
        end
    end

    // Storage is never cleared; invalid output slots are zero-forced instead.
    always_ff @(posedge clk) begin
        if (!rst && !bus.flush_BR && accept) begin
            if (n_in != '0)
                mem[wr_idx0] <= '{pc: bus.i_PC1, ir: bus.i_IR1, ext: bus.i_EXT1};
            if (n_in == CW'(2))
                mem[wr_idx1] <= '{pc: bus.i_PC2, ir: bus.i_IR2, ext: bus.i_EXT2};
        end
    end

    always_comb begin
        e0 = mem[rd_idx0];
        e1 = mem[rd_idx1];
        if (count >= CW'(2))
            valid_out = 2'b11;
        else if (count == CW'(1))
            valid_out = 2'b10;
        else
            valid_out = 2'b00;
    end

    assign bus.o_PC1      = valid_out[1] ? e0.pc  : '0;
    assign bus.o_IR1      = valid_out[1] ? e0.ir  : '0;
    assign bus.o_EXT1     = valid_out[1] ? e0.ext : '0;
    assign bus.o_PC2      = valid_out[0] ? e1.pc  : '0;
    assign bus.o_IR2      = valid_out[0] ? e1.ir  : '0;
    assign bus.o_EXT2     = valid_out[0] ? e1.ext : '0;
    assign bus.o_is_valid = valid_out;
    assign bus.ID_status  = |valid_out;
    assign bus.o_is_full  = (count >= FULL_TH);
    assign bus.o_count    = count;
    assign bus.o_overflow = overflow_q;
endmodule

// File: doc/fetch_queue.md
# fetch_queue

Parametrised instruction queue between IF2 and ID1, successor to the fixed 16-entry dual-slot buffer. Accepts up to two fetched instructions per cycle, each with a PC, IR and a side-band field of width EXT_W for predictor and exception bits, and presents the two oldest entries to the decoder. The decoder consumes 0, 1 or 2 entries per cycle through an explicit dequeue count, so partial consumption is supported. A branch flush empties the queue in one cycle.

## Interface
- DEPTH, 16: number of entries; power of two, at least 4.
- EXT_W, 8: per-instruction side-band width; at least 1.
- FULL_MARGIN, 4: `o_is_full` asserts when occupancy ≥ DEPTH − FULL_MARGIN; range 2..DEPTH−1.
- Derived: CW = $clog2(DEPTH)+1, the width of the occupancy count and of the wrap-bit pointers.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- i_PC1, i_IR1  in  32 each  first (older) fetched instruction.
- i_EXT1  in  EXT_W  side-band for slot 1.
- i_PC2, i_IR2  in  32 each  second fetched instruction.
- i_EXT2  in  EXT_W  side-band for slot 2.
- i_is_valid  in  2  11 = both slots valid, 10 = slot 1 only, 01/00 = none.
- stall_ICache  in  1  masks `i_is_valid` to 00.
- flush_BR  in  1  empties the queue.
- i_deq  in  2  number of entries the decoder consumes this cycle (0/1/2).
- o_PC1, o_IR1, o_EXT1  out  32/32/EXT_W  oldest entry.
- o_PC2, o_IR2, o_EXT2  out  32/32/EXT_W  second-oldest entry.
- o_is_valid  out  2  11 when count ≥ 2, 10 when count = 1, 00 when empty.
- ID_status  out  1  = |o_is_valid.
- o_is_full  out  1  almost-full back-pressure to IF.
- o_count  out  CW  current occupancy, 0..DEPTH.
- o_overflow  out  1  one-cycle pulse when an enqueue is rejected.

## Operation
- Storage is a circular array of DEPTH entries {PC, IR, EXT}. Pointers `head` (write) and `tail` (read) are CW bits wide. The low bits index the array; the MSB is the wrap bit.
- Occupancy: `o_count = head − tail`, modulo 2^CW.
- Enqueue amount: n_in = 2 for 11, 1 for 10, otherwise 0, after masking by stall_ICache.
- Dequeue amount: n_out = min(i_deq, count). i_deq = 3 is treated as 2. Dequeue over-requests are clamped silently.
- Enqueue acceptance:
  - Free space is DEPTH − count, measured before this cycle's dequeue. Space freed by a same-cycle dequeue is not credited.
  - If n_in ≤ free: slot 1 is written at head and slot 2 at head+1 (mod DEPTH), and head advances by n_in.
  - If n_in > free: nothing is written, head holds, and o_overflow pulses. The queue never writes a partial pair.
- Dequeue: tail advances by n_out. Enqueue and dequeue in the same cycle are both applied.
- Output view (show-ahead, combinational from stored entries):
  - Slot 1 shows the entry at tail; slot 2 shows the entry at tail+1 (mod DEPTH).
  - Data of an invalid output slot is forced to all zeros.
- No bypass: an incoming instruction is never visible at the outputs in its arrival cycle.
- Priority: rst > flush_BR > normal operation.
  - flush_BR sets head = tail = 0.
  - Same-cycle inputs and i_deq are ignored during a flush.
  - Array contents are not cleared by a flush.
- rst: head = tail = 0. Array contents are not cleared; the zero-forcing of invalid slots hides them.
- o_is_full = (o_count ≥ DEPTH − FULL_MARGIN), decoded from registered state only.

## Timing
- Latency: an instruction enqueued at edge k appears on the outputs in the cycle after edge k.
- Minimum fetch-to-decode latency is therefore 1 cycle.
- Outputs depend only on registered state (pointers and array), with no combinational path from inputs.
- The decoder samples the outputs and drives i_deq in the same cycle. i_deq is registered at the next edge.
- Full-throughput steady state (2 in, 2 out per cycle) is sustained indefinitely at any constant occupancy ≤ DEPTH−2.
- Pointer wrap is seamless: entry DEPTH−1 followed by entry 0 reads in order, with the wrap bit distinguishing full from empty.
- Values after reset, and in the first cycle after a flush:
  - o_is_valid = 00, ID_status = 0.
  - o_count = 0, o_is_full = 0, o_overflow = 0.
  - All data outputs = 0.
- Reset mid-stream takes effect at the next edge regardless of other inputs.

## Test plan
- Reset then enqueue: assert rst for 2 cycles, then i_is_valid=11 with PC 0x1C000000/0x1C000004 and i_deq=0. Next cycle: o_is_valid=11, o_PC1=0x1C000000, o_PC2=0x1C000004, o_count=2.
- Partial consume: queue holds 3 entries (PC 0x100, 0x104, 0x108); apply i_deq=1 and i_is_valid=00. Next cycle: o_PC1=0x104, o_PC2=0x108, o_count=2, o_is_valid=11.
- Full, back-pressure and overflow (DEPTH=16, FULL_MARGIN=4):
  - Fill to 12 entries: o_is_full=1.
  - Fill to 16 entries: o_count=16.
  - Then apply 11 with i_deq=2: o_overflow=1 for one cycle, o_count=14, and nothing is written.
- Wrap-around: stream 2 in / 2 out with a PC increment of 4 for 40 cycles at occupancy 3. Required: outputs are strictly in PC order across the pointer wrap, and o_count stays at 3.
- Flush priority: at o_count=9, assert flush_BR together with i_is_valid=11 and i_deq=2. Next cycle: o_count=0, o_is_valid=00, data outputs=0. The following enqueue lands at index 0.
- ICache stall and illegal dequeue:
  - With stall_ICache=1 and i_is_valid=11, no enqueue occurs.
  - With count=1 and i_deq=3: o_count=0 the next cycle, with no underflow.
